// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, load-use stall, branch flush, memory wait
module hazard_ctrl #(
  parameter int BRANCH_PENALTY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_rs,
  input  logic       id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       idex_rs,
  input  logic       idex_rt,
  input  logic [1:0] idex_wb,
  input  logic [1:0] idex_m,
  input  logic       exmem_regwrite,
  input  logic       memwb_regwrite,
  input  logic       exmem_rd,
  input  logic       memwb_rd,
  input  logic       branch_taken,
  input  logic       mem_stall,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       exmem_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic [1:0] state,
  output logic [7:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [1:0] PENALTY = 2'(BRANCH_PENALTY);

  state_t     cur_state;
  state_t     saved_state;
  state_t     eff_state;
  state_t     next_state;
  state_t     next_saved;
  logic [1:0] flush_cnt;
  logic [1:0] next_cnt;
  logic       load_use;
  logic       unused_ctl;

  // Only RegWrite and MemRead are meaningful in the ID/EX control fields
  assign unused_ctl = ^{idex_wb[0], idex_m[0]};

  assign state = cur_state;

  // While waiting on memory the block behaves as whatever state the stall interrupted
  assign eff_state = (cur_state == MEM_WAIT) ? saved_state : cur_state;

  // A load in EX whose destination is read by the instruction in ID
  assign load_use = idex_m[1] && idex_wb[1] &&
                    ((id_use_rs && (id_rs == idex_rt)) ||
                     (id_use_rt && (id_rt == idex_rt)));

  // EX operand forwarding; the nearer stage (EX/MEM) wins over MEM/WB
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (!reset) begin
      if (exmem_regwrite && (exmem_rd == idex_rs))
        forward_a = 2'b10;
      else if (memwb_regwrite && (memwb_rd == idex_rs))
        forward_a = 2'b01;
      if (exmem_regwrite && (exmem_rd == idex_rt))
        forward_b = 2'b10;
      else if (memwb_regwrite && (memwb_rd == idex_rt))
        forward_b = 2'b01;
    end
  end

  // Priority decode: reset > mem_stall > flush/branch > load-use > run
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    next_state  = RUN;
    next_saved  = saved_state;
    next_cnt    = flush_cnt;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      next_state  = MEM_WAIT;
      next_saved  = eff_state;
    end else if (eff_state == FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (flush_cnt <= 2'd1) begin
        next_cnt   = 2'd0;
        next_state = RUN;
      end else begin
        next_cnt   = flush_cnt - 2'd1;
        next_state = FLUSH;
      end
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      next_cnt    = PENALTY;
      next_state  = (PENALTY != 2'd0) ? FLUSH : RUN;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Control state, pre-stall state and flush countdown
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state   <= RUN;
      saved_state <= RUN;
      flush_cnt   <= 2'd0;
    end else begin
      cur_state   <= next_state;
      saved_state <= next_saved;
      flush_cnt   <= next_cnt;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clock) begin
    if (reset)
      stall_count <= 8'd0;
    else if (!pc_write && (stall_count != 8'hFF))
      stall_count <= stall_count + 8'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with BRANCH_PENALTY=2
module tb_hazard_ctrl;

  logic       clock;
  logic       reset;
  logic       id_rs, id_rt, id_use_rs, id_use_rt;
  logic       idex_rs, idex_rt;
  logic [1:0] idex_wb, idex_m;
  logic       exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd;
  logic       branch_taken, mem_stall;
  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       ifid_flush, idex_bubble;
  logic [1:0] forward_a, forward_b, state;
  logic [7:0] stall_count;

  typedef struct {
    string      tag;
    logic [3:0] en;
    logic [1:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_ctrl #(.BRANCH_PENALTY(2)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wb(idex_wb), .idex_m(idex_m),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .forward_a(forward_a), .forward_b(forward_b), .state(state),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare the oldest pending expectation at the falling edge
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_en"}, {pc_write, ifid_write, idex_write, exmem_write}, e.en);
      check({e.tag, "_fl"}, {ifid_flush, idex_bubble}, e.fl);
      check({e.tag, "_fa"}, forward_a, e.fa);
      check({e.tag, "_fb"}, forward_b, e.fb);
      check({e.tag, "_st"}, state, e.st);
      check({e.tag, "_sc"}, stall_count, e.sc);
    end
  end

  task automatic idle();
    reset = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    idex_rs = 0; idex_rt = 0; idex_wb = 2'b00; idex_m = 2'b00;
    exmem_regwrite = 0; memwb_regwrite = 0; exmem_rd = 0; memwb_rd = 0;
    branch_taken = 0; mem_stall = 0;
  endtask

  task automatic step(input string tag, input logic [3:0] en, input logic [1:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st,
                      input logic [7:0] sc);
    exp_t x;
    x.tag = tag; x.en = en; x.fl = fl; x.fa = fa; x.fb = fb; x.st = st; x.sc = sc;
    sb.push_back(x);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1; exmem_regwrite = 1; memwb_regwrite = 1;
    @(posedge clock); #1;
    step("rst_a", 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00, 8'd0);
    step("rst_b", 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00, 8'd0);
    idle();
    step("run_idle", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0);

    // forwarding
    exmem_regwrite = 1; memwb_regwrite = 1; idex_rs = 0; idex_rt = 1;
    step("fwd_a_ex", 4'b1111, 2'b00, 2'b10, 2'b00, 2'b00, 8'd0);
    exmem_regwrite = 0;
    step("fwd_a_mem", 4'b1111, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0);
    exmem_regwrite = 1; exmem_rd = 1; memwb_rd = 1;
    step("fwd_b_ex", 4'b1111, 2'b00, 2'b00, 2'b10, 2'b00, 8'd0);
    exmem_regwrite = 0;
    step("fwd_b_mem", 4'b1111, 2'b00, 2'b00, 2'b01, 2'b00, 8'd0);

    // load-use
    idle(); idex_m = 2'b10; idex_wb = 2'b10; idex_rt = 1; id_use_rs = 1; id_rs = 1;
    step("lu_rs", 4'b0011, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0);
    idle();
    step("lu_after", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd1);
    idex_m = 2'b10; idex_wb = 2'b00; idex_rt = 1; id_use_rs = 1; id_rs = 1;
    step("lu_nowb", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd1);
    idex_wb = 2'b10; id_use_rs = 0; id_use_rt = 1; id_rt = 1; id_rs = 0;
    step("lu_rt", 4'b0011, 2'b01, 2'b00, 2'b00, 2'b00, 8'd1);
    id_use_rt = 0; id_rs = 1; id_rt = 1;
    step("lu_nouse", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd2);

    // branch with two flush cycles; branch and load-use held during flush are ignored
    idle(); branch_taken = 1;
    step("br_run", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b00, 8'd2);
    idex_m = 2'b10; idex_wb = 2'b10; idex_rt = 1; id_use_rs = 1; id_rs = 1;
    step("br_fl1", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b01, 8'd2);
    step("br_fl2", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b01, 8'd2);
    idle();
    step("br_done", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd2);

    // memory stall while in flush with one flush cycle left
    branch_taken = 1;
    step("ms_br", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b00, 8'd2);
    idle();
    step("ms_fl", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b01, 8'd2);
    mem_stall = 1;
    step("ms_s0", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01, 8'd2);
    step("ms_s1", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, 8'd3);
    step("ms_s2", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, 8'd4);
    step("ms_s3", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, 8'd5);
    mem_stall = 0;
    step("ms_rel", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b10, 8'd6);
    step("ms_run", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd6);

    // mem_stall outranks branch; saved RUN resumes without a flush
    mem_stall = 1; branch_taken = 1;
    step("pr_stall", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 8'd6);
    mem_stall = 0; branch_taken = 0;
    step("pr_rel", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b10, 8'd7);
    step("pr_run", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd7);

    // reset during MEM_WAIT
    mem_stall = 1;
    step("rw_s0", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 8'd7);
    step("rw_s1", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, 8'd8);
    reset = 1; exmem_regwrite = 1; memwb_regwrite = 1;
    step("rw_rst", 4'b0000, 2'b11, 2'b00, 2'b00, 2'b10, 8'd9);
    idle();
    step("rw_post", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0);

    // reset during FLUSH
    branch_taken = 1;
    step("rf_br", 4'b1111, 2'b11, 2'b00, 2'b00, 2'b00, 8'd0);
    idle(); reset = 1;
    step("rf_rst", 4'b0000, 2'b11, 2'b00, 2'b00, 2'b01, 8'd0);
    idle();
    step("rf_post", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0);

    // saturation after 300 stalled cycles
    mem_stall = 1;
    repeat (300) @(posedge clock);
    #1;
    step("sat_hold", 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10, 8'd255);
    mem_stall = 0;
    step("sat_rel", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b10, 8'd255);
    step("sat_run", 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 8'd255);

    @(negedge clock);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter BRANCH_PENALTY, default 1, meaning extra flush cycles after the branch-detect cycle (legal range 0..3).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_rs, id_rt  input  1 each  source register numbers in ID.
REQ-005 SHALL have ports id_use_rs, id_use_rt  input  1 each  the ID instruction reads that operand.
REQ-006 SHALL have ports idex_rs, idex_rt  input  1 each  register numbers held in ID/EX.
REQ-007 SHALL have ports idex_wb, idex_m  input  2 each  ID/EX control fields; bit1 of wb is RegWrite, bit1 of m is MemRead.
REQ-008 SHALL have ports exmem_regwrite, memwb_regwrite  input  1 each  later-stage write enables.
REQ-009 SHALL have ports exmem_rd, memwb_rd  input  1 each  later-stage destination registers.
REQ-010 SHALL have port branch_taken  input  1  branch resolved taken in EX.
REQ-011 SHALL have port mem_stall  input  1  data memory not ready (level).
REQ-012 SHALL have ports pc_write, ifid_write, idex_write, exmem_write  output  1 each  stage load enables.
REQ-013 SHALL have ports ifid_flush, idex_bubble  output  1 each  zero IF/ID, and zero ID/EX control fields, at the next edge.
REQ-014 SHALL have ports forward_a, forward_b  output  2 each  EX operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-015 SHALL have port state  output  2  RUN=00, FLUSH=01, MEM_WAIT=10.
REQ-016 SHALL have port stall_count  output  8  saturating count of cycles with pc_write=0.

Function
REQ-017 SHALL set forward_a=10 when exmem_regwrite and exmem_rd==idex_rs; else 01 when memwb_regwrite and memwb_rd==idex_rs; else 00. forward_b SHALL follow the same rule using idex_rt. Forwarding SHALL be combinational and independent of state.
REQ-018 SHALL detect load-use when idex_m[1] and idex_wb[1] are both 1 and either (id_use_rs and id_rs==idex_rt) or (id_use_rt and id_rt==idex_rt).
REQ-019 SHALL apply a one-level priority each cycle: reset > mem_stall > branch/flush > load-use > run.
REQ-020 While mem_stall=1 (any state): all four write enables=0, ifid_flush=0, idex_bubble=0, state goes to MEM_WAIT next cycle, and the pre-stall state and flush counter SHALL be preserved.
REQ-021 In MEM_WAIT with mem_stall=0, the block SHALL act as the saved state this cycle and return to it next cycle.
REQ-022 In RUN with branch_taken=1: ifid_flush=1, idex_bubble=1, all write enables=1; load counter with BRANCH_PENALTY; next state FLUSH if BRANCH_PENALTY>0, else RUN.
REQ-023 In FLUSH: ifid_flush=1, idex_bubble=1, write enables=1; decrement counter; return to RUN on the cycle the counter reaches 0 after decrement. branch_taken and load-use SHALL be ignored in FLUSH.
REQ-024 In RUN with load-use (and no branch_taken): pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1, exmem_write=1; state stays RUN.
REQ-025 In RUN with no event: all enables=1, flush/bubble=0.
REQ-026 stall_count SHALL increment on every cycle with pc_write=0 and reset deasserted, and SHALL hold at 255.

Reset
REQ-027 With reset=1 at a rising edge: state=RUN, flush counter=0, saved state=RUN, stall_count=0.
REQ-028 While reset=1: pc_write=ifid_write=idex_write=exmem_write=0, ifid_flush=1, idex_bubble=1, forward_a=forward_b=00.
REQ-029 Reset mid-FLUSH or mid-MEM_WAIT SHALL abandon the sequence; the first post-reset cycle behaves as RUN.

Verification
REQ-030 Load-use: idex_m=10, idex_wb=10, idex_rt=1, id_use_rs=1, id_rs=1 -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle; stall_count 0->1.
REQ-031 Branch with BRANCH_PENALTY=2: branch_taken pulse -> ifid_flush=1 for 3 consecutive cycles, state RUN,FLUSH,FLUSH,RUN.
REQ-032 mem_stall held 4 cycles during FLUSH (counter=1) -> enables=0 for 4 cycles, state=MEM_WAIT; after release exactly one more flush cycle, then RUN.
REQ-033 Forwarding: exmem_rd=memwb_rd=idex_rs=0, both regwrite=1 -> forward_a=10; exmem_regwrite=0 -> forward_a=01.
REQ-034 Saturation: 300 consecutive mem_stall cycles -> stall_count=255.
REQ-035 Reset asserted during MEM_WAIT -> next cycle state=00, stall_count=0, outputs per REQ-028 while reset=1.
